// File: rtl/xbar_pkg.sv
// Shared types and constants for the crossbar output arbiter slice.
package xbar_pkg;

    localparam int ports = 4;
    localparam int SELW  = $clog2(ports);

    typedef enum logic {
        ARB_IDLE,
        ARB_XFER
    } arb_state_t;

    // Increment with wrap-around at n; used for round-robin pointers.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/xbar_out_arbiter_if.sv
// Request/grant and mux-control bundle between crossbar inputs and the arbiter.
interface xbar_out_arbiter_if #(
    parameter int PORTS = xbar_pkg::ports
);
    localparam int SELW = (PORTS > 1) ? $clog2(PORTS) : 1;

    logic [PORTS-1:0]      req;
    logic [PORTS*SELW-1:0] dest;
    logic [PORTS-1:0]      gnt;
    logic [PORTS-1:0]      busy_in;
    logic [PORTS*SELW-1:0] mux_sel;
    logic [PORTS-1:0]      mux_en;
    logic [PORTS-1:0]      done;

    modport master (
        output req, dest,
        input  gnt, busy_in, mux_sel, mux_en, done
    );

    modport slave (
        input  req, dest,
        output gnt, busy_in, mux_sel, mux_en, done
    );

endinterface

// File: rtl/xbar_rr_pick.sv
// Combinational round-robin picker: first set bit of eligible at or above ptr, wrapping.
module xbar_rr_pick #(
    parameter int PORTS = 4,
    parameter int SELW  = 2
) (
    input  logic [PORTS-1:0] eligible,
    input  logic [SELW-1:0]  ptr,
    output logic [SELW-1:0]  winner,
    output logic             valid
);

    always_comb begin
        // NOTE: every output gets a default before the search so no path leaves it unassigned (no latch).
        winner = '0;
        valid  = 1'b0;
        for (int k = 0; k < PORTS; k++) begin
            if (!valid && eligible[(int'(ptr) + k) % PORTS]) begin
                valid  = 1'b1;
                winner = SELW'((int'(ptr) + k) % PORTS);
            end
        end
    end

endmodule

// File: rtl/xbar_out_arbiter.sv
// Per-output round-robin arbiter: fixed-length transfers, zero-bubble re-grant on the done beat.
module xbar_out_arbiter
    import xbar_pkg::*;
#(
    parameter int PORTS    = xbar_pkg::ports,
    parameter int XFER_LEN = 8
) (
    input  logic               clk,
    input  logic               rst,
    xbar_out_arbiter_if.slave  bus
);

    localparam int SELW = (PORTS > 1) ? $clog2(PORTS) : 1;
    localparam int CNTW = $clog2(XFER_LEN);
    localparam logic [CNTW-1:0] LAST = CNTW'(XFER_LEN - 1);

    arb_state_t       state [PORTS];
    logic [CNTW-1:0]  cnt   [PORTS];
    logic [SELW-1:0]  rr    [PORTS];

    logic [PORTS-1:0] busy;
    logic [PORTS-1:0] ending;
    logic [PORTS-1:0] free;
    logic [PORTS-1:0] elig   [PORTS];
    logic [SELW-1:0]  winner [PORTS];
    logic [PORTS-1:0] win_valid;

    // Which inputs are sourcing a transfer, and which of those finish this cycle.
    always_comb begin
        busy   = '0;
        ending = '0;
        for (int o = 0; o < PORTS; o++) begin
            if (bus.mux_en[o]) begin
                busy[bus.mux_sel[o*SELW +: SELW]] = 1'b1;
                if (bus.done[o]) ending[bus.mux_sel[o*SELW +: SELW]] = 1'b1;
            end
        end
    end

    assign bus.busy_in = busy;

    always_comb begin
        for (int o = 0; o < PORTS; o++) begin
            free[o] = (state[o] == ARB_IDLE) || bus.done[o];
            elig[o] = '0;
            for (int i = 0; i < PORTS; i++) begin
                elig[o][i] = bus.req[i]
                          && (int'(bus.dest[i*SELW +: SELW]) == o)
                          && (int'(bus.dest[i*SELW +: SELW]) < PORTS)
                          && !bus.gnt[i]
                          && (!busy[i] || ending[i]);
            end
        end
    end

    for (genvar o = 0; o < PORTS; o++) begin : g_pick
        xbar_rr_pick #(
            .PORTS (PORTS),
            .SELW  (SELW)
        ) u_pick (
            .eligible (elig[o]),
            .ptr      (rr[o]),
            .winner   (winner[o]),
            .valid    (win_valid[o])
        );
    end

    // NOTE: state is updated with non-blocking assignments so every output sees the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < PORTS; o++) begin
                state[o] <= ARB_IDLE;
                cnt[o]   <= '0;
                rr[o]    <= '0;
            end
            bus.mux_sel <= '0;
            bus.mux_en  <= '0;
            bus.gnt     <= '0;
            bus.done    <= '0;
        end else begin
            bus.gnt <= '0;
            for (int o = 0; o < PORTS; o++) begin
                if (free[o]) begin
                    if (win_valid[o]) begin
                        state[o]                     <= ARB_XFER;
                        cnt[o]                       <= '0;
                        bus.mux_sel[o*SELW +: SELW]  <= winner[o];
                        bus.mux_en[o]                <= 1'b1;
                        bus.gnt[winner[o]]           <= 1'b1;
                        rr[o]                        <= SELW'(wrap_inc(int'(winner[o]), PORTS));
                        bus.done[o]                  <= 1'b0;
                    end else begin
                        // mux_sel and rr deliberately hold their last values.
                        state[o]      <= ARB_IDLE;
                        cnt[o]        <= '0;
                        bus.mux_en[o] <= 1'b0;
                        bus.done[o]   <= 1'b0;
                    end
                end else begin
                    cnt[o]      <= cnt[o] + 1'b1;
                    bus.done[o] <= (cnt[o] + 1'b1 == LAST);
                end
            end
        end
    end

endmodule

// File: tb/tb_xbar_out_arbiter.sv
// Directed self-checking bench for xbar_out_arbiter (PORTS=4, XFER_LEN=8).
module tb_xbar_out_arbiter;
    import xbar_pkg::*;

    localparam int P  = 4;
    localparam int L  = 8;
    localparam int SW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xbar_out_arbiter_if #(.PORTS(P)) bus ();

    xbar_out_arbiter #(
        .PORTS    (P),
        .XFER_LEN (L)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_dest(input int i, input int d);
        bus.dest[i*SW +: SW] = SW'(d);
    endtask

    function automatic logic [SW-1:0] sel_of(input int o);
        return bus.mux_sel[o*SW +: SW];
    endfunction

    initial begin
        logic [3:0] exp_g;

        // Reset with every input requesting.
        bus.req  = 4'hF;
        bus.dest = '0;
        rst      = 1'b1;
        tick();
        tick();
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_en", 32'(bus.mux_en), 32'h0);
        check("rst_done", 32'(bus.done), 32'h0);
        for (int o = 0; o < P; o++) check($sformatf("rst_rr%0d", o), 32'(dut.rr[o]), 32'h0);
        bus.req = '0;
        rst     = 1'b0;
        tick();
        check("idle_en", 32'(bus.mux_en), 32'h0);

        // Single request: input 2 -> output 1.
        set_dest(2, 1);
        bus.req = 4'b0100;
        tick();
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("single_gnt_c%0d", c), 32'(bus.gnt), (c == 1) ? 32'h4 : 32'h0);
            check($sformatf("single_en_c%0d", c), 32'(bus.mux_en), 32'h2);
            check($sformatf("single_sel_c%0d", c), 32'(sel_of(1)), 32'd2);
            check($sformatf("single_done_c%0d", c), 32'(bus.done), (c == 8) ? 32'h2 : 32'h0);
            check($sformatf("single_busy_c%0d", c), 32'(bus.busy_in), 32'h4);
            if (c == 1) bus.req = '0;
            tick();
        end
        check("single_en_after", 32'(bus.mux_en), 32'h0);
        check("single_sel_hold", 32'(sel_of(1)), 32'd2);
        check("single_done_after", 32'(bus.done), 32'h0);

        // Contention: inputs 0, 1, 3 -> output 2, requesting continuously.
        set_dest(0, 2);
        set_dest(1, 2);
        set_dest(2, 0);
        set_dest(3, 2);
        bus.req = 4'b1011;
        tick();
        for (int c = 1; c <= 32; c++) begin
            case (c)
                1, 25:   exp_g = 4'b0001;
                9:       exp_g = 4'b0010;
                17:      exp_g = 4'b1000;
                default: exp_g = 4'b0000;
            endcase
            check($sformatf("cont_gnt_c%0d", c), 32'(bus.gnt), 32'(exp_g));
            check($sformatf("cont_en_c%0d", c), 32'(bus.mux_en), 32'h4);
            check($sformatf("cont_done_c%0d", c), 32'(bus.done), (c % 8 == 0) ? 32'h4 : 32'h0);
            if (c == 1 || c == 25) check($sformatf("cont_sel_c%0d", c), 32'(sel_of(2)), 32'd0);
            if (c == 9)  check("cont_sel_c9", 32'(sel_of(2)), 32'd1);
            if (c == 17) check("cont_sel_c17", 32'(sel_of(2)), 32'd3);
            if (c == 32) bus.req = '0;
            tick();
        end
        check("cont_en_after", 32'(bus.mux_en), 32'h0);

        // Parallel: every input to a distinct output.
        set_dest(0, 3);
        set_dest(1, 2);
        set_dest(2, 1);
        set_dest(3, 0);
        bus.req = 4'hF;
        tick();
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("par_gnt_c%0d", c), 32'(bus.gnt), (c == 1) ? 32'hF : 32'h0);
            check($sformatf("par_en_c%0d", c), 32'(bus.mux_en), 32'hF);
            check($sformatf("par_sel_c%0d", c), 32'(bus.mux_sel), 32'h1B);
            check($sformatf("par_done_c%0d", c), 32'(bus.done), (c == 8) ? 32'hF : 32'h0);
            if (c == 1) bus.req = '0;
            tick();
        end
        check("par_en_after", 32'(bus.mux_en), 32'h0);

        // Busy input: input 1 is on output 2 and asks for output 0.
        set_dest(1, 2);
        bus.req = 4'b0010;
        tick();
        check("busy_gnt_c1", 32'(bus.gnt), 32'h2);
        check("busy_en_c1", 32'(bus.mux_en), 32'h4);
        set_dest(1, 0);
        tick();
        for (int c = 2; c <= 8; c++) begin
            check($sformatf("busy_gnt_c%0d", c), 32'(bus.gnt), 32'h0);
            check($sformatf("busy_in_c%0d", c), 32'(bus.busy_in), 32'h2);
            check($sformatf("busy_en_c%0d", c), 32'(bus.mux_en), 32'h4);
            check($sformatf("busy_done_c%0d", c), 32'(bus.done), (c == 8) ? 32'h4 : 32'h0);
            tick();
        end
        check("busy_gnt_c9", 32'(bus.gnt), 32'h2);
        check("busy_en_c9", 32'(bus.mux_en), 32'h1);
        check("busy_sel_c9", 32'(sel_of(0)), 32'd1);
        check("busy_in_c9", 32'(bus.busy_in), 32'h2);
        bus.req = '0;
        repeat (8) tick();
        check("busy_en_after", 32'(bus.mux_en), 32'h0);

        // Mid-transfer reset: input 0 -> output 0, reset on beat 4.
        set_dest(0, 0);
        bus.req = 4'b0001;
        tick();
        check("mrst_gnt_c1", 32'(bus.gnt), 32'h1);
        check("mrst_rr_pre", 32'(dut.rr[0]), 32'd1);
        bus.req = '0;
        repeat (4) tick();
        check("mrst_en_c5", 32'(bus.mux_en), 32'h1);
        check("mrst_done_c5", 32'(bus.done), 32'h0);
        rst = 1'b1;
        tick();
        check("mrst_gnt", 32'(bus.gnt), 32'h0);
        check("mrst_en", 32'(bus.mux_en), 32'h0);
        check("mrst_done", 32'(bus.done), 32'h0);
        check("mrst_sel", 32'(bus.mux_sel), 32'h0);
        check("mrst_rr0", 32'(dut.rr[0]), 32'd0);
        rst = 1'b0;
        set_dest(3, 0);
        bus.req = 4'b1000;
        tick();
        check("post_gnt", 32'(bus.gnt), 32'h8);
        check("post_sel", 32'(sel_of(0)), 32'd3);
        check("post_en", 32'(bus.mux_en), 32'h1);
        check("post_rr0", 32'(dut.rr[0]), 32'd0);
        bus.req = '0;
        for (int c = 2; c <= 8; c++) begin
            tick();
            check($sformatf("post_done_c%0d", c), 32'(bus.done), (c == 8) ? 32'h1 : 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/xbar_out_arbiter.md
XBAR_OUT_ARBITER -- requirements
Module: xbar_out_arbiter

Interface
REQ-001 The block SHALL have parameter PORTS, default xbar_pkg::ports (4): number of crossbar input and output ports.
REQ-002 The block SHALL have parameter XFER_LEN, default 8: beats per packet transfer; legal values are 2..255.
REQ-003 The block SHALL have port clk  in  1  single system clock; all logic on rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port req  in  PORTS  input i has a packet pending.
REQ-006 The block SHALL have port dest  in  PORTS*SELW  flattened destination output index of input i (SELW = $clog2(PORTS)).
REQ-007 The block SHALL have port gnt  out  PORTS  one-cycle pulse: input i granted.
REQ-008 The block SHALL have port busy_in  out  PORTS  input i currently sourcing a transfer.
REQ-009 The block SHALL have port mux_sel  out  PORTS*SELW  per output o, selected input index.
REQ-010 The block SHALL have port mux_en  out  PORTS  output o is carrying a transfer this cycle.
REQ-011 The block SHALL have port done  out  PORTS  output o is on its last beat this cycle.

Function
REQ-012 Each output o SHALL run an independent FSM with states ARB_IDLE and ARB_XFER plus a beat counter cnt[o] (0..XFER_LEN-1).
REQ-013 Input i SHALL be eligible for output o at an edge iff req[i], dest[i]==o, dest[i]<PORTS, !gnt[i], and (!busy_in[i] or input i's current output has done=1).
REQ-014 Output o SHALL be free at an edge iff state is ARB_IDLE, or state is ARB_XFER with done[o]=1.
REQ-015 When free with at least one eligible input, output o SHALL select the first eligible input searching upward from pointer rr[o] with wrap-around past PORTS-1 to 0.
REQ-016 On a selection, the block SHALL register: state ARB_XFER, cnt 0, mux_sel[o]=winner, mux_en[o]=1, gnt[winner]=1 for one cycle, and rr[o]=(winner+1) mod PORTS.
REQ-017 Latency SHALL be one cycle: req sampled at edge k gives gnt and mux_en in the cycle after edge k.
REQ-018 In ARB_XFER, cnt SHALL increment each cycle, and done[o] SHALL be 1 exactly when cnt==XFER_LEN-1.
REQ-019 A free output with no eligible input SHALL go to ARB_IDLE with mux_en 0 and mux_sel holding its last value; rr[o] SHALL be unchanged.
REQ-020 Back-to-back transfers SHALL have zero bubble: re-grant on a done cycle gives mux_en continuously high.
REQ-021 busy_in[i] SHALL be 1 iff some o has mux_en[o]=1 and mux_sel[o]==i (combinational from registers).
REQ-022 Requester protocol: a requester SHALL hold req until it sees gnt; the cycle gnt=1 may still show req=1, and that req is ignored.
REQ-023 Requests whose dest is out of range, or whose input is busy and not ending, SHALL be ignored without state change.
REQ-024 Different outputs SHALL grant in the same cycle without interaction, since each input names exactly one dest.

Reset
REQ-025 While rst=1 at an edge, the block SHALL set all states to ARB_IDLE, cnt=0, rr=0, mux_sel=0, mux_en=0, gnt=0 and done=0.
REQ-026 A reset asserted mid-transfer SHALL abort it with no done pulse, and the first post-reset arbitration SHALL start from pointer 0.

Structure
REQ-027 xbar_pkg SHALL hold ports, SELW, and the typedef enum arb_state_t {ARB_IDLE, ARB_XFER}.
REQ-028 The design SHALL instantiate one sub-module, xbar_rr_pick, per output: a combinational round-robin picker (eligible vector, pointer -> winner, valid).
REQ-029 The design SHALL keep the FSM, counters and pointers in xbar_out_arbiter; all outputs except busy_in SHALL be registered.

Verification (PORTS=4, XFER_LEN=8)
REQ-030 Reset test: hold rst 2 cycles with req=4'hF -> gnt, mux_en and done all 0 and rr=0 for every output.
REQ-031 Single request: req[2]=1, dest[2]=1 at edge 0 -> gnt=4'b0100 in cycle 1; mux_en[1]=1 and mux_sel[1]=2 in cycles 1-8; done[1]=1 in cycle 8 only.
REQ-032 Contention: inputs 0, 1 and 3 all dest 2 and re-requesting immediately -> grants 0,1,3,0 at cycles 1, 9, 17, 25, with mux_en[2] continuously 1.
REQ-033 Parallel test: dest 3,2,1,0 for inputs 0-3, all requesting at once -> gnt=4'hF in cycle 1, all mux_en high cycles 1-8.
REQ-034 Busy input: input 1 transferring to output 2 requests output 0 -> not granted until its done cycle, then gnt on the next cycle with busy_in[1] continuous.
REQ-035 Mid-transfer reset: rst at beat 4 -> next cycle all outputs 0 with no done; a re-request from input 3 to output 0 is granted with rr[0] reset (winner 3, rr[0]=0 after).
